// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator. A local command
// port (cmd_*) starts one write or read; the result returns on rsp_*.
// Ports: m_axi_aclk / m_axi_areset (sync, active-high); cmd_valid/ready,
// cmd_write, cmd_addr, cmd_wdata, cmd_wstrb in; rsp_valid/ready, rsp_rdata,
// rsp_resp out; busy, err_count status; m_axi_aw*/w*/b*/ar*/r* master.
module axi_lite_master #(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 4
) (
   input  logic                              m_axi_aclk,
   input  logic                              m_axi_areset,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                        rsp_resp,
   output logic                              busy,
   output logic [7:0]                        err_count,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [2:0]                        m_axi_awprot,
   output logic                              m_axi_awvalid,
   input  logic                              m_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                              m_axi_wvalid,
   input  logic                              m_axi_wready,
   input  logic [1:0]                        m_axi_bresp,
   input  logic                              m_axi_bvalid,
   output logic                              m_axi_bready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic [2:0]                        m_axi_arprot,
   output logic                              m_axi_arvalid,
   input  logic                              m_axi_arready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                        m_axi_rresp,
   input  logic                              m_axi_rvalid,
   output logic                              m_axi_rready
);

   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int SW = C_M_AXI_DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_ADDR_DATA,
      S_WR_RESP,
      S_RD_ADDR,
      S_RD_DATA,
      S_RESP
   } state_t;

   state_t          state_q, state_d;
   logic            awvalid_q, awvalid_d;
   logic            wvalid_q, wvalid_d;
   logic            bready_q, bready_d;
   logic            arvalid_q, arvalid_d;
   logic            rready_q, rready_d;
   logic            aw_done_q, aw_done_d;
   logic            w_done_q, w_done_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]      rsp_resp_q, rsp_resp_d;
   logic [AW-1:0]   awaddr_q, awaddr_d;
   logic [AW-1:0]   araddr_q, araddr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]   wstrb_q, wstrb_d;
   logic [7:0]      err_q, err_d;
   logic            cap;

   // Reset gates cmd_ready so no command is taken while reset is held.
   assign cmd_ready = (state_q == S_IDLE) && !m_axi_areset;
   assign busy      = (state_q != S_IDLE);

   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      awaddr_d    = awaddr_q;
      araddr_d    = araddr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      err_d       = err_q;
      cap         = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               awaddr_d = cmd_addr;
               araddr_d = cmd_addr;
               wdata_d  = cmd_wdata;
               wstrb_d  = cmd_wstrb;
               if (cmd_write) begin
                  state_d   = S_WR_ADDR_DATA;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
               end else begin
                  state_d   = S_RD_ADDR;
                  arvalid_d = 1'b1;
               end
            end
         end
         S_WR_ADDR_DATA: begin
            // AW and W retire independently, in any order.
            if (awvalid_q && m_axi_awready) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (wvalid_q && m_axi_wready) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if (aw_done_d && w_done_d) begin
               state_d  = S_WR_RESP;
               bready_d = 1'b1;
            end
         end
         S_WR_RESP: begin
            if (m_axi_bvalid) begin
               bready_d    = 1'b0;
               rsp_rdata_d = '0;
               rsp_resp_d  = m_axi_bresp;
               rsp_valid_d = 1'b1;
               cap         = 1'b1;
               state_d     = S_RESP;
            end
         end
         S_RD_ADDR: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (m_axi_rvalid) begin
               rready_d    = 1'b0;
               rsp_rdata_d = m_axi_rdata;
               rsp_resp_d  = m_axi_rresp;
               rsp_valid_d = 1'b1;
               cap         = 1'b1;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Saturating error counter, no wrap.
      if (cap && (rsp_resp_d != 2'b00) && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end
   end

   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         state_q     <= S_IDLE;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= 2'b00;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         err_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
         awaddr_q    <= awaddr_d;
         araddr_q    <= araddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         err_q       <= err_d;
      end
   end

   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign err_count     = err_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Testbench for axi_lite_master: directed commands against a behavioural
// AXI4-Lite slave; expected responses are queued and checked by a monitor.
module tb_axi_lite_master;

   logic        clk = 1'b0;
   logic        areset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [3:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        busy;
   logic [7:0]  err_count;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
   logic        arready = 1'b0, rvalid = 1'b0;
   logic [1:0]  bresp = 2'b00, rresp = 2'b00;
   logic [31:0] rdata = 32'h0;

   always #5 clk = ~clk;

   axi_lite_master dut (
      .m_axi_aclk(clk), .m_axi_areset(areset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .busy(busy), .err_count(err_count),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
      .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arprot(arprot),
      .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] d;
      logic [1:0]  r;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t        exp_q[$];
   int          exp_err = 0;
   int          rsp_cnt = 0;
   int          last_hs = 0;
   bit          prev_v = 0;
   logic [31:0] hold_d;
   logic [1:0]  hold_r;

   always begin
      @(negedge clk);
      if (areset) begin
         prev_v = 0;
      end else begin
         if (rsp_valid) begin
            chk("cmd_ready_in_resp", cmd_ready, 0);
            if (!prev_v) begin
               hold_d = rsp_rdata;
               hold_r = rsp_resp;
               chk("rsp_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0 && exp_q[0].lat)
                  chk("rsp_latency", cyc + 1 - exp_q[0].acc, 4);
            end else begin
               chk("rsp_rdata_stable", rsp_rdata, hold_d);
               chk("rsp_resp_stable", rsp_resp, hold_r);
            end
            if (rsp_ready && exp_q.size() > 0) begin
               exp_t e;
               e = exp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, e.d);
               chk("rsp_resp", rsp_resp, e.r);
               if (e.r != 2'b00 && exp_err < 255) exp_err++;
               chk("err_count", err_count, exp_err);
               rsp_cnt++;
               last_hs = cyc + 1;
            end
         end
         prev_v = rsp_valid && !rsp_ready;
      end
   end

   // ---------------- slave BFM ----------------
   logic [31:0] mem [4];
   int          cfg_aw_dly = 0;
   int          cfg_w_dly = 0;
   logic [1:0]  cfg_bresp = 2'b00;
   logic [1:0]  cfg_rresp = 2'b00;
   bit          cfg_b_hold = 0;
   int          bcnt = 0;

   initial for (int i = 0; i < 4; i++) mem[i] = 32'hFFFF_FFFF;

   always begin
      logic        n_aw, n_w, n_b, n_ar, n_r;
      logic [1:0]  n_bresp, n_rresp;
      logic [31:0] n_rdata, w_first, w_d;
      logic [3:0]  aw_a, w_s;
      bit          aw_got, w_got, w_seen;
      int          aw_cnt, w_cnt;
      aw_got = 0; w_got = 0; w_seen = 0; aw_cnt = 0; w_cnt = 0;
      aw_a = 0; w_s = 0; w_d = 0; w_first = 0;
      forever begin
         @(negedge clk);
         n_aw = awready; n_w = wready; n_b = bvalid;
         n_ar = arready; n_r = rvalid;
         n_bresp = bresp; n_rresp = rresp; n_rdata = rdata;
         if (areset) begin
            n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
            aw_got = 0; w_got = 0; w_seen = 0;
            aw_cnt = 0; w_cnt = 0;
         end else begin
            if (aw_got) chk("awvalid_drop", awvalid, 0);
            if (wvalid && w_seen) chk("wdata_stable", wdata, w_first);
            if (awvalid) begin
               if (awready) begin
                  aw_got = 1; aw_a = awaddr; n_aw = 0;
               end else if (aw_cnt == cfg_aw_dly) begin
                  n_aw = 1; aw_cnt = 0;
               end else aw_cnt++;
            end
            if (wvalid) begin
               if (!w_seen) begin
                  w_seen = 1; w_first = wdata;
               end
               if (wready) begin
                  w_got = 1; w_d = wdata; w_s = wstrb;
                  n_w = 0; w_seen = 0;
               end else if (w_cnt == cfg_w_dly) begin
                  n_w = 1; w_cnt = 0;
               end else w_cnt++;
            end
            if (bvalid && bready) begin
               n_b = 0;
               bcnt++;
            end else if (aw_got && w_got && !bvalid && !cfg_b_hold) begin
               if (cfg_bresp == 2'b00)
                  for (int i = 0; i < 4; i++)
                     if (w_s[i]) mem[aw_a[3:2]][8*i +: 8] = w_d[8*i +: 8];
               n_b = 1; n_bresp = cfg_bresp;
               aw_got = 0; w_got = 0;
            end
            if (arvalid && arready) begin
               n_ar = 0; n_r = 1;
               n_rdata = mem[araddr[3:2]];
               n_rresp = cfg_rresp;
            end else if (arvalid) n_ar = 1;
            if (rvalid && rready) n_r = 0;
         end
         @(posedge clk);
         #1;
         awready = n_aw; wready = n_w; bvalid = n_b; bresp = n_bresp;
         arready = n_ar; rvalid = n_r; rdata = n_rdata; rresp = n_rresp;
      end
   end

   // ---------------- driver ----------------
   task automatic drive_cmd(input bit w, input logic [3:0] a,
                            input logic [31:0] d, input logic [3:0] s);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_wstrb = s;
   endtask

   task automatic accept(input bit push, input logic [31:0] ed,
                         input logic [1:0] er, input bit lat,
                         output int acc);
      int n;
      n = 0;
      acc = -1;
      do begin
         @(negedge clk);
         n++;
      end while (!cmd_ready && n < 100);
      chk("cmd_accept", cmd_ready, 1);
      if (cmd_ready) acc = cyc + 1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      if (push && acc >= 0) exp_q.push_back('{ed, er, acc, lat});
   endtask

   task automatic send(input bit w, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] ed, input logic [1:0] er,
                       input bit lat, output int acc);
      drive_cmd(w, a, d, s);
      accept(1, ed, er, lat, acc);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, b0, r0, n;
      areset = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0;
      cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_resp", rsp_resp, 0);
      chk("rst_addrs", {awaddr, araddr}, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_wstrb", wstrb, 0);
      chk("rst_err_count", err_count, 0);
      chk("prot", {awprot, arprot}, 0);
      @(posedge clk);
      #1 areset = 1'b0;
      @(negedge clk);
      chk("cmd_ready_after_rst", cmd_ready, 1);
      @(posedge clk);
      #1;

      // write then read back, zero wait states
      send(1, 4'h8, 32'hA5A5_0F0F, 4'hF, 32'h0, 2'b00, 1, a0);
      send(0, 4'h8, 32'h0, 4'h0, 32'hA5A5_0F0F, 2'b00, 1, a1);
      chk("cmd_spacing", a1 - a0, 5);
      wait_drain();

      // partial strobe
      send(1, 4'h0, 32'h1234_5678, 4'h3, 32'h0, 2'b00, 1, a0);
      send(0, 4'h0, 32'h0, 4'h0, 32'hFFFF_5678, 2'b00, 1, a0);
      wait_drain();

      // SLVERR write response
      cfg_bresp = 2'b10;
      send(1, 4'h4, 32'h1111_1111, 4'hF, 32'h0, 2'b10, 1, a0);
      wait_drain();
      cfg_bresp = 2'b00;

      // AW before W, then W before AW
      b0 = bcnt; r0 = rsp_cnt;
      cfg_aw_dly = 0; cfg_w_dly = 3;
      send(1, 4'hC, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 0, a0);
      wait_drain();
      chk("b_handshakes", bcnt - b0, 1);
      chk("rsp_count", rsp_cnt - r0, 1);
      cfg_aw_dly = 3; cfg_w_dly = 0;
      send(1, 4'hC, 32'h0BAD_F00D, 4'hC, 32'h0, 2'b00, 0, a0);
      wait_drain();
      cfg_aw_dly = 0; cfg_w_dly = 0;
      send(0, 4'hC, 32'h0, 4'h0, 32'h0BAD_BEEF, 2'b00, 1, a0);
      wait_drain();

      // error saturation
      cfg_rresp = 2'b10;
      for (int i = 0; i < 300; i++)
         send(0, 4'h4, 32'h0, 4'h0, 32'hFFFF_FFFF, 2'b10, 1, a0);
      wait_drain();
      chk("err_saturated", err_count, 255);
      cfg_rresp = 2'b00;

      // response back-pressure with next command pending
      rsp_ready = 1'b0;
      send(0, 4'h8, 32'h0, 4'h0, 32'hA5A5_0F0F, 2'b00, 1, a0);
      drive_cmd(0, 4'h0, 32'h0, 4'h0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 50);
      chk("bp_rsp_valid", rsp_valid, 1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_rsp_valid_hold", rsp_valid, 1);
         chk("bp_cmd_ready", cmd_ready, 0);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      accept(1, 32'hFFFF_5678, 2'b00, 1, a1);
      chk("accept_after_hs", a1, last_hs + 1);
      wait_drain();

      // reset while waiting for B
      cfg_b_hold = 1;
      r0 = rsp_cnt;
      drive_cmd(1, 4'h4, 32'h7777_7777, 4'hF);
      accept(0, 32'h0, 2'b00, 0, a0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bready && n < 20);
      chk("in_wr_resp", bready, 1);
      @(posedge clk);
      #1 areset = 1'b1;
      @(negedge clk);
      chk("cmd_ready_in_rst", cmd_ready, 0);
      @(posedge clk);
      #1 areset = 1'b0;
      exp_err = 0;
      cfg_b_hold = 0;
      @(negedge clk);
      chk("mid_rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_err", err_count, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      repeat (10) @(negedge clk);
      chk("no_rsp_after_rst", rsp_cnt - r0, 0);
      @(posedge clk);
      #1;
      send(0, 4'h8, 32'h0, 4'h0, 32'hA5A5_0F0F, 2'b00, 1, a0);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
